slt_arbiter: RTL

Round-robin arbiter that shares one 16-bit set-less-than comparator between several requesters, such as the decode/execute slots issuing SLT/SLTI and the branch-compare path. Each requester presents two operands through a valid/ready handshake. The block picks one requester per cycle, evaluates A < B and returns the zero-extended 1-bit result, tagged with the requester index, through a single-entry output register with backpressure. It sits between the issue logic and the writeback mux, replacing per-requester comparators.

---
 rtl/slt_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/slt_arbiter.sv
// slt_arbiter: round-robin arbiter sharing one W-bit set-less-than comparator among NREQ requesters.
// Define SLT_ARB_SIGNED_EN to honour req_signed per requester; otherwise every compare is unsigned.
module slt_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_signed,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_out,
   output logic [IDW-1:0]    res_id
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic [IDW-1:0] idx;
   logic           found;
   logic           grant_en;
   logic           xfer;
   logic           lt;
   logic [W-1:0]   a_arr [NREQ];
   logic [W-1:0]   b_arr [NREQ];
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*W +: W];
      assign b_arr[i] = req_b[i*W +: W];
   end
   // scan ptr, ptr+1, ... modulo NREQ and keep the first valid requester
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end
   assign grant_en  = (state == EMPTY) || res_ready;
   assign xfer      = found && grant_en && !rst;
   assign req_ready = xfer ? NREQ'(1) << win : '0;
   assign res_valid = (state == FULL);
`ifdef SLT_ARB_SIGNED_EN
   assign lt = req_signed[win] ? ($signed(a_arr[win]) < $signed(b_arr[win])) : (a_arr[win] < b_arr[win]);
`else
   logic unused_signed;
   assign unused_signed = ^req_signed;
   assign lt = a_arr[win] < b_arr[win];
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         ptr     <= '0;
         res_out <= '0;
         res_id  <= '0;
      end else if (xfer) begin
         state   <= FULL;
         res_out <= W'(lt);
         res_id  <= win;
         ptr     <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      end else if (res_ready) begin
         state <= EMPTY;
      end
   end
endmodule
